// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: divides the APU tick into sequencer steps and emits the
// quarter-frame / half-frame clocks plus the sticky 4-step frame interrupt.
module apu_frame_sequencer #(
  parameter int STEP_DIV  = 3729,
  parameter int DIV_WIDTH = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       cfg_wr,
  input  logic       cfg_mode,
  input  logic       cfg_irq_inhibit,
  input  logic       irq_ack,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       frame_irq,
  output logic [2:0] step
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } step_e;

  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(STEP_DIV - 1);

  logic [DIV_WIDTH-1:0] div;
  step_e                cur;
  logic                 mode;
  logic                 irq_inhibit;

  step_e next_step;
  logic  q_hit;
  logic  h_hit;
  logic  irq_hit;
  logic  boundary;

  // A config write restarts the sequence, so a coinciding boundary is dropped.
  assign boundary = tick && (div == DIV_LAST) && !cfg_wr;

  // Pulse pattern and successor for the step being left at the next boundary.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    q_hit     = 1'b0;
    h_hit     = 1'b0;
    irq_hit   = 1'b0;
    next_step = S0;
    case (cur)
      S0: begin
        q_hit     = 1'b1;
        next_step = S1;
      end
      S1: begin
        q_hit     = 1'b1;
        h_hit     = 1'b1;
        next_step = S2;
      end
      S2: begin
        q_hit     = 1'b1;
        next_step = S3;
      end
      S3: begin
        if (!mode) begin
          q_hit     = 1'b1;
          h_hit     = 1'b1;
          irq_hit   = !irq_inhibit;
          next_step = S0;
        end else begin
          next_step = S4;
        end
      end
      S4: begin
        q_hit     = 1'b1;
        h_hit     = 1'b1;
        next_step = S0;
      end
      default: next_step = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div           <= '0;
      cur           <= S0;
      mode          <= 1'b0;
      irq_inhibit   <= 1'b0;
      quarter_frame <= 1'b0;
      half_frame    <= 1'b0;
      frame_irq     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments; the pulse defaults
      // below are overridden later in the same block to make one-clk pulses.
      quarter_frame <= 1'b0;
      half_frame    <= 1'b0;
      if (cfg_wr) begin
        mode          <= cfg_mode;
        irq_inhibit   <= cfg_irq_inhibit;
        div           <= '0;
        cur           <= S0;
        quarter_frame <= cfg_mode;
        half_frame    <= cfg_mode;
      end else if (tick) begin
        if (div == DIV_LAST) begin
          div           <= '0;
          cur           <= next_step;
          quarter_frame <= q_hit;
          half_frame    <= h_hit;
        end else begin
          div <= div + 1'b1;
        end
      end
      // Setting the interrupt takes priority over any clear in the same cycle.
      if (boundary && irq_hit) begin
        frame_irq <= 1'b1;
      end else if (irq_ack || (cfg_wr && cfg_irq_inhibit)) begin
        frame_irq <= 1'b0;
      end
    end
  end

  assign step = cur;

endmodule
